bus_slave_mem: RTL and testbench

- Serial-bus responder (slave) for the shared 1-bit half-duplex bus driven by the bus master.
- Deserialises the 16-bit address, acknowledges valid addresses and decodes direction.
- Writes: receives an 8-bit data word into a local byte memory, then acknowledges.
- Reads: serialises the addressed byte back to the master.
- Sits behind the address decoder/arbiter; one instance per slave slot.

---
 rtl/bus_slave_mem.sv | 193 +++++++++++++++++++
 tb/tb_bus_slave_mem.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_mem.sv
// bus_slave_mem: serial-bus responder with a local byte memory.
// Deserialises a 16-bit address (LSB first), acknowledges selected in-range
// addresses, then either receives an 8-bit write word or serialises the
// addressed byte back to the master.
// Ports:
//   CLK        clock, all logic on the rising edge
//   RST        synchronous active-high reset
//   S_UTIL     bus-in-use qualifier; a bit is taken/advanced only when 1
//   S_RW       transfer direction, 1 = write, 0 = read (sampled in ACK_A)
//   S_VALID    decoder select, sampled with address bit 15
//   S_BUS_IN   serial address / write data from the master
//   S_BUS_OUT  serial read data to the master (registered)
//   S_ACK      one-cycle acknowledge pulse (registered)
//   S_BSY      high whenever the FSM is not in IDLE (registered)
module bus_slave_mem #(
    parameter int unsigned MEM_ADDR_W = 12,
    parameter int unsigned ADDR_LSB   = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic S_UTIL,
    input  logic S_RW,
    input  logic S_VALID,
    input  logic S_BUS_IN,
    output logic S_BUS_OUT,
    output logic S_ACK,
    output logic S_BSY
);

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned MEM_DEPTH = 2 ** MEM_ADDR_W;
    localparam int unsigned IDX_HI    = ADDR_LSB + MEM_ADDR_W;

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ACK_A,
        WDATA,
        ACK_W,
        RDATA,
        WAIT_IDLE
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_d;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   data;
    logic [DATA_W-1:0]   data_d;
    logic                ack_d;
    logic                bus_out_d;
    logic                mem_we;
    logic                rd_load;

    logic [DATA_W-1:0]     mem [MEM_DEPTH];
    logic [MEM_ADDR_W-1:0] mem_idx;
    logic [DATA_W-1:0]     mem_rd;

    assign mem_idx = addr[IDX_HI-1:ADDR_LSB];
    assign mem_rd  = mem[mem_idx];

    // Next-state, datapath and output decode
    always_comb begin
        state_d   = state;
        count_d   = count;
        addr_d    = addr;
        data_d    = data;
        bus_out_d = 1'b0;
        mem_we    = 1'b0;
        rd_load   = 1'b0;

        case (state)
            IDLE: begin
                if (S_UTIL) begin
                    // First qualified bit is address bit 0; stale upper bits are dropped.
                    addr_d  = ADDR_W'(S_BUS_IN);
                    count_d = CNT_W'(1);
                    state_d = ADDR;
                end
            end

            ADDR: begin
                if (!S_UTIL) begin
                    addr_d  = '0;
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    addr_d[count] = S_BUS_IN;
                    count_d       = count + CNT_W'(1);
                    if (count == ADDR_LAST) begin
                        // Decode uses the just-completed address including bit 15.
                        if (S_VALID && (addr_d[ADDR_W-1:IDX_HI] == '0)) begin
                            state_d = ACK_A;
                        end else begin
                            state_d = WAIT_IDLE;
                        end
                    end
                end
            end

            ACK_A: begin
                count_d = '0;
                if (S_RW) begin
                    state_d = WDATA;
                end else begin
                    state_d = RDATA;
                    rd_load = 1'b1;
                end
            end

            WDATA: begin
                if (!S_UTIL) begin
                    count_d = '0;
                    state_d = IDLE;
                end else begin
                    data_d[count[2:0]] = S_BUS_IN;
                    count_d            = count + CNT_W'(1);
                    if (count == DATA_LAST) begin
                        state_d = ACK_W;
                    end
                end
            end

            ACK_W: begin
                // A reset landing in this cycle drops the pending write.
                mem_we  = !RST;
                state_d = WAIT_IDLE;
            end

            RDATA: begin
                if (S_UTIL) begin
                    count_d = count + CNT_W'(1);
                    if (count == DATA_LAST) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        bus_out_d = data[3'(count + CNT_W'(1))];
                    end
                end else begin
                    // Master stall: hold the current bit on the wire.
                    bus_out_d = S_BUS_OUT;
                end
            end

            WAIT_IDLE: begin
                if (!S_UTIL) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        ack_d = (state_d == ACK_A) || (state_d == ACK_W);
    end

    // State, datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            count     <= '0;
            addr      <= '0;
            data      <= '0;
            S_ACK     <= 1'b0;
            S_BUS_OUT <= 1'b0;
            S_BSY     <= 1'b0;
        end else begin
            state     <= state_d;
            count     <= count_d;
            addr      <= addr_d;
            data      <= rd_load ? mem_rd : data_d;
            S_ACK     <= ack_d;
            S_BUS_OUT <= rd_load ? mem_rd[0] : bus_out_d;
            S_BSY     <= (state_d != IDLE);
        end
    end

    // Byte memory write port; contents survive reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[mem_idx] <= data;
        end
    end

endmodule

// File: tb/tb_bus_slave_mem.sv
// tb_bus_slave_mem: directed self-checking bench for bus_slave_mem.
// Inputs change 1 ns after each rising edge and outputs are sampled there.
// Read data expectations come from a byte model and are queued per bit.
module tb_bus_slave_mem;

    logic CLK;
    logic RST;
    logic S_UTIL;
    logic S_RW;
    logic S_VALID;
    logic S_BUS_IN;
    logic S_BUS_OUT;
    logic S_ACK;
    logic S_BSY;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model [int];
    logic       exp_q [$];

    bus_slave_mem #(
        .MEM_ADDR_W (12),
        .ADDR_LSB   (2)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .S_UTIL    (S_UTIL),
        .S_RW      (S_RW),
        .S_VALID   (S_VALID),
        .S_BUS_IN  (S_BUS_IN),
        .S_BUS_OUT (S_BUS_OUT),
        .S_ACK     (S_ACK),
        .S_BSY     (S_BSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bus cycle and let the DUT take one rising edge.
    task automatic send_bit(input logic util, input logic b);
        S_UTIL   = util;
        S_BUS_IN = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_addr(input logic [15:0] a, input logic valid, input logic rw);
        logic exp_ack;
        exp_ack = valid && (a[15:14] == 2'b00);
        S_VALID = valid;
        S_RW    = rw;
        for (int i = 0; i < 16; i++) begin
            send_bit(1'b1, a[i]);
            if (i == 7) check("addr_mid_ack", S_ACK, 0);
            if (i == 7) check("addr_mid_bsy", S_BSY, 1);
        end
        check("addr_ack", S_ACK, exp_ack);
        check("addr_ack_busout", S_BUS_OUT, 0);
        S_VALID = 1'b0;
    endtask

    task automatic write_txn(input logic [15:0] a, input logic [7:0] d);
        send_addr(a, 1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        check("wr_ack_a_len", S_ACK, 0);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, d[i]);
            if (i < 7) check("wr_data_no_ack", S_ACK, 0);
        end
        check("wr_ack_w", S_ACK, 1);
        model[int'(a[13:2])] = d;
        send_bit(1'b0, 1'b0);
        check("wr_ack_w_len", S_ACK, 0);
        check("wr_wait_bsy", S_BSY, 1);
        send_bit(1'b0, 1'b0);
        check("wr_idle_bsy", S_BSY, 0);
    endtask

    // Read a byte; if stall_at is 0..7 the master holds S_UTIL low for 3
    // cycles while that bit is on the wire.
    task automatic read_txn(input logic [15:0] a, input int stall_at);
        logic [7:0] exp_byte;
        logic       e;
        exp_byte = model[int'(a[13:2])];
        send_addr(a, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("rd_ack_a_len", S_ACK, 0);
        for (int i = 0; i < 8; i++) exp_q.push_back(exp_byte[i]);
        for (int k = 0; k < 8; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < 3; s++) begin
                    send_bit(1'b0, 1'b0);
                    check("rd_stall_hold", S_BUS_OUT, exp_q[0]);
                end
            end
            e = exp_q.pop_front();
            check($sformatf("rd_bit%0d", k), S_BUS_OUT, e);
            send_bit(1'b1, 1'b0);
        end
        check("rd_after_busout", S_BUS_OUT, 0);
        check("rd_after_bsy", S_BSY, 1);
        check("rd_no_ack", S_ACK, 0);
        send_bit(1'b0, 1'b0);
        check("rd_idle_bsy", S_BSY, 0);
    endtask

    initial begin
        RST      = 1'b1;
        S_UTIL   = 1'b0;
        S_RW     = 1'b0;
        S_VALID  = 1'b0;
        S_BUS_IN = 1'b0;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        check("rst_bsy", S_BSY, 0);
        check("rst_ack", S_ACK, 0);
        check("rst_busout", S_BUS_OUT, 0);
        RST = 1'b0;

        // Basic write then read-back of 0xA5 at index 5
        write_txn(16'h0014, 8'hA5);
        read_txn(16'h0014, -1);

        // Deselected address: no ACK, trailing cycles ignored
        send_addr(16'h0014, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, 1'b1);
            check("desel_ack", S_ACK, 0);
        end
        check("desel_bsy", S_BSY, 1);
        send_bit(1'b0, 1'b0);
        check("desel_idle", S_BSY, 0);

        // Out-of-range address: no ACK
        send_addr(16'h4000, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, 1'b0);
            check("range_ack", S_ACK, 0);
        end
        send_bit(1'b0, 1'b0);
        check("range_idle", S_BSY, 0);
        read_txn(16'h0014, -1);

        // Stall after bit 3
        read_txn(16'h0014, 3);

        // Abort write after data bit 4
        send_addr(16'h0014, 1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, i[0]);
        send_bit(1'b0, 1'b0);
        check("abort_bsy", S_BSY, 0);
        check("abort_ack", S_ACK, 0);
        read_txn(16'h0014, -1);

        // Reset during ADDR
        S_VALID = 1'b1;
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1);
        RST = 1'b1;
        send_bit(1'b1, 1'b1);
        check("rst_addr_bsy", S_BSY, 0);
        check("rst_addr_ack", S_ACK, 0);
        RST     = 1'b0;
        S_VALID = 1'b0;
        send_bit(1'b0, 1'b0);
        write_txn(16'h0008, 8'h5A);
        read_txn(16'h0008, -1);

        // Reset in ACK_W drops the pending write
        send_addr(16'h0014, 1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
        check("rst_ackw_ack", S_ACK, 1);
        RST = 1'b1;
        send_bit(1'b0, 1'b0);
        check("rst_ackw_ack_off", S_ACK, 0);
        check("rst_ackw_bsy", S_BSY, 0);
        RST = 1'b0;
        read_txn(16'h0014, -1);

        // Memory boundaries with random data
        write_txn(16'h0000, 8'($urandom_range(0, 255)));
        write_txn(16'h3FFC, 8'($urandom_range(0, 255)));
        read_txn(16'h0000, 0);
        read_txn(16'h3FFC, 7);
        read_txn(16'h0014, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
